// File: rtl/boss_ctrl_param_if.sv
// Control/status bundle between the boss core and its surroundings.
// master drives game inputs and observes boss state; slave is the boss core.
interface boss_ctrl_param_if #(
    parameter int unsigned HP_W = 7
);
    logic [1:0]      game_active;
    logic            game_start;
    logic            frame_tick;
    logic [11:0]     char_x;
    logic            projectile_hit;
    logic            melee_hit;

    logic [11:0]     boss_x;
    logic [11:0]     boss_y;
    logic [HP_W-1:0] boss_hp;
    logic            boss_alive;
    logic [2:0]      boss_phase;
    logic            hit_flash;
    logic            defeated;

    modport master (
        output game_active, game_start, frame_tick, char_x, projectile_hit, melee_hit,
        input  boss_x, boss_y, boss_hp, boss_alive, boss_phase, hit_flash, defeated
    );

    modport slave (
        input  game_active, game_start, frame_tick, char_x, projectile_hit, melee_hit,
        output boss_x, boss_y, boss_hp, boss_alive, boss_phase, hit_flash, defeated
    );
endinterface

// File: rtl/boss_ctrl_param.sv
// Boss core: HP, damage with invulnerability frames, phase FSM and
// phase-dependent chase movement, all in one registered block.
module boss_ctrl_param #(
    parameter int unsigned HP_MAX    = 100,
    parameter int unsigned HP_W      = 7,
    parameter int unsigned PROJ_DMG  = 2,
    parameter int unsigned MELEE_DMG = 5,
    parameter int unsigned IFRAMES   = 30,
    parameter int unsigned PHASE2_HP = 60,
    parameter int unsigned ENRAGE_HP = 25,
    parameter int unsigned SPD_P1    = 1,
    parameter int unsigned SPD_P2    = 2,
    parameter int unsigned SPD_ENR   = 4,
    parameter int unsigned DEADZONE  = 8,
    parameter int unsigned X_MIN     = 0,
    parameter int unsigned X_MAX     = 900,
    parameter int unsigned X_START   = 700,
    parameter int unsigned Y_GROUND  = 500
) (
    input  logic              clk,
    input  logic              rst,
    boss_ctrl_param_if.slave  bus
);
    localparam int unsigned IFR_W = $clog2(IFRAMES + 1);
    localparam int unsigned DW    = HP_W + 1;
    localparam int unsigned XW    = 13;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_P1     = 3'd1,
        S_P2     = 3'd2,
        S_ENRAGE = 3'd3,
        S_DEAD   = 3'd4
    } phase_e;

    phase_e            phase_q, phase_d;
    logic [HP_W-1:0]   hp_q, hp_d;
    logic [11:0]       x_q, x_d;
    logic [11:0]       y_q, y_d;
    logic [IFR_W-1:0]  ifr_q, ifr_d;
    logic              flash_q, flash_d;
    logic              alive_q, alive_d;
    logic              defeated_q, defeated_d;

    logic              run;
    logic              accept;
    logic [DW-1:0]     dmg;
    logic [DW-1:0]     hp_ext;
    logic [XW-1:0]     bx, cx, dz, step, gap, amt, room;

    function automatic logic [XW-1:0] min_x(input logic [XW-1:0] a, input logic [XW-1:0] b);
        return (a < b) ? a : b;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q    <= S_IDLE;
            hp_q       <= HP_W'(HP_MAX);
            x_q        <= 12'(X_START);
            y_q        <= 12'(Y_GROUND);
            ifr_q      <= '0;
            flash_q    <= 1'b0;
            alive_q    <= 1'b1;
            defeated_q <= 1'b0;
        end else begin
            phase_q    <= phase_d;
            hp_q       <= hp_d;
            x_q        <= x_d;
            y_q        <= y_d;
            ifr_q      <= ifr_d;
            flash_q    <= flash_d;
            alive_q    <= alive_d;
            defeated_q <= defeated_d;
        end
    end

    always_comb begin
        phase_d = phase_q;
        hp_d    = hp_q;
        x_d     = x_q;
        y_d     = 12'(Y_GROUND);
        ifr_d   = ifr_q;
        step    = '0;
        gap     = '0;
        amt     = '0;
        room    = '0;

        run    = ((phase_q == S_P1) || (phase_q == S_P2) || (phase_q == S_ENRAGE))
                 && (bus.game_active == 2'b01);
        dmg    = (bus.projectile_hit ? DW'(PROJ_DMG)  : DW'(0))
               + (bus.melee_hit      ? DW'(MELEE_DMG) : DW'(0));
        accept = run && (ifr_q == '0) && (bus.projectile_hit || bus.melee_hit);
        hp_ext = {1'b0, hp_q};
        bx     = {1'b0, x_q};
        cx     = {1'b0, bus.char_x};
        dz     = XW'(DEADZONE);

        // Damage and invulnerability window; the counter never ticks in the accept cycle
        if (accept) begin
            hp_d  = (dmg >= hp_ext) ? '0 : HP_W'(hp_ext - dmg);
            ifr_d = IFR_W'(IFRAMES);
        end else if (run && bus.frame_tick && (ifr_q != '0)) begin
            ifr_d = ifr_q - IFR_W'(1);
        end

        // Phase steps look at registered HP, so they lag the HP update by one cycle
        case (phase_q)
            S_IDLE: begin
                if (bus.game_active == 2'b01) phase_d = S_P1;
            end
            S_P1, S_P2, S_ENRAGE: begin
                if (run) begin
                    if (hp_q == '0)
                        phase_d = S_DEAD;
                    else if ((phase_q == S_P1) && (hp_q <= HP_W'(PHASE2_HP)))
                        phase_d = S_P2;
                    else if ((phase_q == S_P2) && (hp_q <= HP_W'(ENRAGE_HP)))
                        phase_d = S_ENRAGE;
                end
            end
            default: ;
        endcase

        case (phase_q)
            S_P1:     step = XW'(SPD_P1);
            S_P2:     step = XW'(SPD_P2);
            S_ENRAGE: step = XW'(SPD_ENR);
            default:  step = '0;
        endcase

        // Chase the player outside the deadzone, never overshooting it or the arena
        if (run && bus.frame_tick) begin
            if (cx > bx + dz) begin
                gap  = cx - bx - dz;
                room = XW'(X_MAX) - bx;
                amt  = min_x(min_x(step, gap), room);
                x_d  = 12'(bx + amt);
            end else if (cx + dz < bx) begin
                gap  = bx - cx - dz;
                room = bx - XW'(X_MIN);
                amt  = min_x(min_x(step, gap), room);
                x_d  = 12'(bx - amt);
            end
        end

        if (bus.game_start) begin
            phase_d = S_IDLE;
            hp_d    = HP_W'(HP_MAX);
            x_d     = 12'(X_START);
            ifr_d   = '0;
        end

        flash_d    = (ifr_d != '0);
        alive_d    = (phase_d != S_DEAD);
        defeated_d = (phase_d == S_DEAD) && (phase_q != S_DEAD);
    end

    assign bus.boss_x     = x_q;
    assign bus.boss_y     = y_q;
    assign bus.boss_hp    = hp_q;
    assign bus.boss_alive = alive_q;
    assign bus.boss_phase = 3'(phase_q);
    assign bus.hit_flash  = flash_q;
    assign bus.defeated   = defeated_q;
endmodule

// File: doc/boss_ctrl_param.md
Name: boss_ctrl_param

Overview:
- Parametrised next-generation boss core: merges HP, movement and phase logic into one sequential block with a phase FSM (IDLE/P1/P2/ENRAGE/DEAD).
- Adds melee damage, invulnerability frames, phase-dependent chase speed and a defeat pulse.
- Sits under the boss top level. Drives boss_render (position, HP, alive) and game-state logic (defeated).

Parameters:
HP_MAX, 100, starting/maximum HP
HP_W, 7, HP width; HP_MAX < 2**HP_W
PROJ_DMG, 2, HP removed per accepted projectile hit
MELEE_DMG, 5, HP removed per accepted melee hit
IFRAMES, 30, frame_ticks of invulnerability after an accepted hit (>=1)
PHASE2_HP, 60, HP at or below which P1 -> P2
ENRAGE_HP, 25, HP at or below which P2 -> ENRAGE (< PHASE2_HP)
SPD_P1, 1, pixels per frame_tick in P1
SPD_P2, 2, pixels per frame_tick in P2
SPD_ENR, 4, pixels per frame_tick in ENRAGE
DEADZONE, 8, no movement while |char_x - boss_x| <= DEADZONE
X_MIN, 0, leftmost boss_x
X_MAX, 900, rightmost boss_x
X_START, 700, boss_x after reset/game_start
Y_GROUND, 500, constant boss_y

Ports:
clk  in  1  system clock
rst  in  1  reset, synchronous active-high
game_active  in  2  2'b01 = fight running; any other value = paused/menu
game_start  in  1  one-cycle pulse, re-arms the fight
frame_tick  in  1  one-cycle pulse per video frame
char_x  in  12  player x position
projectile_hit  in  1  projectile-hit pulse
melee_hit  in  1  melee-hit pulse
boss_x  out  12  boss x, registered
boss_y  out  12  boss y, registered
boss_hp  out  HP_W  current HP, registered
boss_alive  out  1  high unless in DEAD
boss_phase  out  3  one-hot-free encoding: 0 IDLE, 1 P1, 2 P2, 3 ENRAGE, 4 DEAD
hit_flash  out  1  high while the invulnerability counter is non-zero
defeated  out  1  one-cycle pulse on entry to DEAD

Behaviour:
- One clock, all outputs registered. Reset is synchronous active-high, as decided.
- rst or game_start forces: boss_hp=HP_MAX, phase=IDLE, boss_x=X_START, boss_y=Y_GROUND, boss_alive=1, iframe counter=0, hit_flash=0, defeated=0.
  - game_start has priority over hits, movement and ticks in the same cycle.
- "run" = phase in {P1,P2,ENRAGE} and game_active==2'b01. When not running, the block holds HP, position, phase and iframe counter; hits are dropped.
- FSM transitions:
  - IDLE -> P1 on the cycle after game_active==2'b01 is seen.
  - P1 -> P2 when boss_hp <= PHASE2_HP.
  - P2 -> ENRAGE when boss_hp <= ENRAGE_HP.
  - P1/P2/ENRAGE -> DEAD when boss_hp==0. DEAD has priority and may skip phases.
  - Transitions evaluate the registered HP, so the phase changes one cycle after the HP update.
  - One phase step per cycle, except that DEAD is direct.
  - DEAD is left only via rst/game_start.
- Damage:
  - A hit is accepted when run and the iframe counter==0.
  - dmg = (projectile_hit?PROJ_DMG:0) + (melee_hit?MELEE_DMG:0). Simultaneous hits sum into a single acceptance.
  - Subtraction saturates at 0, computed at HP_W+1 bits. boss_hp updates on the next edge.
  - On acceptance, the iframe counter loads IFRAMES.
  - The counter decrements by 1 on each frame_tick while run and non-zero. It is not decremented in the acceptance cycle.
  - Hits arriving while the counter is non-zero are ignored.
  - hit_flash = (counter != 0), registered alongside the counter.
- Movement happens only on frame_tick while run:
  - step = SPD_P1/SPD_P2/SPD_ENR for the current phase.
  - If char_x > boss_x+DEADZONE: boss_x += min(step, char_x-boss_x-DEADZONE).
  - If char_x+DEADZONE < boss_x: boss_x -= min(step, boss_x-char_x-DEADZONE).
  - Result is clamped to [X_MIN, X_MAX]. All comparisons are 13-bit unsigned, so there is no wrap.
  - boss_y is held at Y_GROUND.
- defeated is high for exactly one cycle, the one in which the phase register first reads DEAD. It is low otherwise.
- boss_alive = (phase != DEAD), registered with the phase.
- Out-of-range char_x (> X_MAX) is legal: the boss chases to X_MAX and stops.

Test Plan:
- Reset, then game_active=01: boss_hp=100, boss_x=700, boss_y=500, phase 0 then 1 one cycle later; boss_alive=1, defeated=0.
- Single projectile_hit in P1: boss_hp=98 next cycle, hit_flash=1. A second hit 5 ticks later is ignored (HP stays 98). After 30 frame_ticks hit_flash=0 and a further hit gives 96.
- projectile_hit and melee_hit in the same cycle at HP=100: HP=93, one iframe window. At HP=3 a melee hit gives HP=0 (saturating), the phase reads 4 one cycle later, defeated pulses once, and boss_alive=0.
- Drive HP 62 -> 60 -> 25: phase 1 -> 2 one cycle after HP=60; 2 -> 3 one cycle after HP=25. With char_x=100 and boss_x=700, boss_x drops by 1, then 2, then 4 per frame_tick in the respective phases.
- Movement boundaries:
  - char_x=704: no motion (deadzone).
  - char_x=4000 in ENRAGE with boss_x=898: boss_x becomes 900 and holds.
  - char_x=703 with boss_x=700 in P2: no motion.
- game_active=10 mid-fight: HP, position and iframes are frozen, and hits are ignored. game_start in the same cycle as a hit restores HP=100, boss_x=700, phase 0, with the hit discarded.
